// File: rtl/gshare_param_bp_if.sv
// Fetch/execute port bundle for the parametrised gshare predictor.
// Statistics outputs exist only when BP_STATS_EN is defined.
interface gshare_param_bp_if #(
  parameter int IDX_W = 10,
  parameter int GHR_W = 10,
  parameter int PC_W  = 32
);
  logic             branch_en_F;
  logic             stall_F;
  logic [PC_W-1:0]  PC_F;
  logic             BP_decision_F;
  logic [IDX_W-1:0] pred_idx_F;
  logic             branch_en_EX;
  logic [IDX_W-1:0] idx_EX;
  logic             branch_result;
  logic             branch_correction;
  logic [GHR_W-1:0] ghr_spec;
`ifdef BP_STATS_EN
  logic [31:0]      stat_lookups;
  logic [31:0]      stat_resolved;
  logic [31:0]      stat_mispredicts;

  modport master (
    output branch_en_F, stall_F, PC_F,
    output branch_en_EX, idx_EX, branch_result, branch_correction,
    input  BP_decision_F, pred_idx_F, ghr_spec,
    input  stat_lookups, stat_resolved, stat_mispredicts
  );
  modport slave (
    input  branch_en_F, stall_F, PC_F,
    input  branch_en_EX, idx_EX, branch_result, branch_correction,
    output BP_decision_F, pred_idx_F, ghr_spec,
    output stat_lookups, stat_resolved, stat_mispredicts
  );
`else
  modport master (
    output branch_en_F, stall_F, PC_F,
    output branch_en_EX, idx_EX, branch_result, branch_correction,
    input  BP_decision_F, pred_idx_F, ghr_spec
  );
  modport slave (
    input  branch_en_F, stall_F, PC_F,
    input  branch_en_EX, idx_EX, branch_result, branch_correction,
    output BP_decision_F, pred_idx_F, ghr_spec
  );
`endif
endinterface

// File: rtl/gshare_param_bp.sv
// Parametrised gshare direction predictor with speculative/architectural GHR.
// Define BP_STATS_EN to add lookup/resolve/mispredict counters.
module gshare_param_bp #(
  parameter int IDX_W = 10,
  parameter int GHR_W = 10,
  parameter int CTR_W = 2,
  parameter int PC_W  = 32
) (
  input logic          clk,
  input logic          rst,
  gshare_param_bp_if.slave bp
);
  localparam int N = 2**IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2**(CTR_W-1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

  logic [CTR_W-1:0] pht_q [N];
  logic [GHR_W-1:0] ghr_spec_q, ghr_spec_d;
  logic [GHR_W-1:0] ghr_arch_q, ghr_arch_d;
  logic [IDX_W-1:0] hist_ext;
  logic [IDX_W-1:0] idx_f;
  logic [CTR_W-1:0] ctr_rd;
  logic [CTR_W-1:0] ctr_old;
  logic [CTR_W-1:0] ctr_d;
  logic             dec;
  logic             fetch_adv;
  logic             mispred;
  logic             unused_pc;

  function automatic logic [GHR_W-1:0] shl(
    input logic [GHR_W-1:0] h,
    input logic             b
  );
    logic [GHR_W:0] t;
    t = {h, b};
    return t[GHR_W-1:0];
  endfunction

  always_comb begin
    hist_ext = '0;
    hist_ext[GHR_W-1:0] = ghr_spec_q;
  end

  assign idx_f     = bp.PC_F[IDX_W+1:2] ^ hist_ext;
  assign ctr_rd    = pht_q[idx_f];
  assign dec       = ~rst & bp.branch_en_F & ctr_rd[CTR_W-1];
  assign fetch_adv = bp.branch_en_F & ~bp.stall_F;
  assign mispred   = bp.branch_en_EX & bp.branch_correction;
  assign ctr_old   = pht_q[bp.idx_EX];
  assign unused_pc = ^{bp.PC_F[1:0], bp.PC_F[PC_W-1:IDX_W+2]};

  assign bp.BP_decision_F = dec;
  assign bp.pred_idx_F    = idx_f;
  assign bp.ghr_spec      = ghr_spec_q;

  always_comb begin
    ctr_d = ctr_old;
    if (bp.branch_result) begin
      if (ctr_old != CTR_MAX) ctr_d = ctr_old + CTR_ONE;
    end else if (ctr_old != '0) begin
      ctr_d = ctr_old - CTR_ONE;
    end
  end

  // Recovery rebuilds from the pre-resolve arch history plus the true outcome.
  always_comb begin
    ghr_arch_d = ghr_arch_q;
    ghr_spec_d = ghr_spec_q;
    if (bp.branch_en_EX) ghr_arch_d = shl(ghr_arch_q, bp.branch_result);
    if (mispred)
      ghr_spec_d = shl(ghr_arch_q, bp.branch_result);
    else if (fetch_adv)
      ghr_spec_d = shl(ghr_spec_q, dec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) pht_q[i] <= CTR_INIT;
      ghr_spec_q <= '0;
      ghr_arch_q <= '0;
    end else begin
      if (bp.branch_en_EX) pht_q[bp.idx_EX] <= ctr_d;
      ghr_spec_q <= ghr_spec_d;
      ghr_arch_q <= ghr_arch_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_lookups_d     = stat_lookups_q;
    stat_resolved_d    = stat_resolved_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (fetch_adv)       stat_lookups_d     = stat_lookups_q + 32'd1;
    if (bp.branch_en_EX) stat_resolved_d    = stat_resolved_q + 32'd1;
    if (mispred)         stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups_q     <= '0;
      stat_resolved_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_resolved_q    <= stat_resolved_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bp.stat_lookups     = stat_lookups_q;
  assign bp.stat_resolved    = stat_resolved_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_gshare_param_bp.sv
// Self-checking bench for gshare_param_bp: table-level model plus directed literals.
// Stats checks are compiled in when BP_STATS_EN is defined.
module tb_gshare_param_bp;
  localparam int IDX_W = 10;
  localparam int GHR_W = 10;
  localparam int CTR_W = 2;
  localparam int PC_W  = 32;
  localparam int MASK  = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int m_pht [1024];
  int m_gs;
  int m_ga;

  gshare_param_bp_if #(.IDX_W(IDX_W), .GHR_W(GHR_W), .PC_W(PC_W)) bif ();

  gshare_param_bp #(
    .IDX_W(IDX_W), .GHR_W(GHR_W), .CTR_W(CTR_W), .PC_W(PC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp(bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  function automatic int exp_idx();
    return ((int'(bif.PC_F) >> 2) & MASK) ^ m_gs;
  endfunction

  // Model: counters as plain ints in 0..3, histories as shifted ints.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) m_pht[i] = 1;
      m_gs = 0;
      m_ga = 0;
    end else begin
      int li, d, b, wi;
      li = exp_idx();
      d  = (bif.branch_en_F && m_pht[li] >= 2) ? 1 : 0;
      b  = bif.branch_result ? 1 : 0;
      wi = int'(bif.idx_EX);
      if (bif.branch_en_EX) begin
        if (b == 1) m_pht[wi] = (m_pht[wi] == 3) ? 3 : m_pht[wi] + 1;
        else        m_pht[wi] = (m_pht[wi] == 0) ? 0 : m_pht[wi] - 1;
      end
      if (bif.branch_en_EX && bif.branch_correction)
        m_gs = ((m_ga << 1) | b) & MASK;
      else if (bif.branch_en_F && !bif.stall_F)
        m_gs = ((m_gs << 1) | d) & MASK;
      if (bif.branch_en_EX) m_ga = ((m_ga << 1) | b) & MASK;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int ei;
      logic ed;
      ei = exp_idx();
      ed = !rst && bif.branch_en_F && (m_pht[ei] >= 2);
      chk("model_dec", 32'(bif.BP_decision_F), 32'(ed));
      chk("model_idx", 32'(bif.pred_idx_F), 32'(ei));
      chk("model_ghr", 32'(bif.ghr_spec), 32'(m_gs));
    end
  end

  task automatic drive(
    input logic            en_f,
    input logic            stall,
    input logic [PC_W-1:0] pc,
    input logic            en_ex,
    input logic [IDX_W-1:0] idx,
    input logic            res,
    input logic            corr
  );
    @(negedge clk);
    #1;
    bif.branch_en_F       = en_f;
    bif.stall_F           = stall;
    bif.PC_F              = pc;
    bif.branch_en_EX      = en_ex;
    bif.idx_EX            = idx;
    bif.branch_result     = res;
    bif.branch_correction = corr;
    #1;
  endtask

  localparam logic [9:0] ARCH_PAT = 10'h2A5;

  initial begin
    bif.branch_en_F = 0;
    bif.stall_F = 0;
    bif.PC_F = '0;
    bif.branch_en_EX = 0;
    bif.idx_EX = '0;
    bif.branch_result = 0;
    bif.branch_correction = 0;
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    drive(1, 0, 32'h40, 0, 0, 0, 0);
    chk("rst_dec", 32'(bif.BP_decision_F), 0);
    chk("rst_ghr", 32'(bif.ghr_spec), 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // First lookup after reset
    drive(1, 0, 32'h40, 0, 0, 0, 0);
    chk("lk0_dec", 32'(bif.BP_decision_F), 0);
    chk("lk0_idx", 32'(bif.pred_idx_F), 32'h010);
    chk("lk0_ghr", 32'(bif.ghr_spec), 0);
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    chk("lk0_ghr_next", 32'(bif.ghr_spec), 0);

    // Train up to saturation
    drive(0, 0, 32'h0, 1, 10'h010, 1, 0);
    drive(0, 0, 32'h0, 1, 10'h010, 1, 0);
    drive(1, 1, 32'h40, 0, 0, 0, 0);
    chk("sat_taken", 32'(bif.BP_decision_F), 1);
    drive(0, 0, 32'h0, 1, 10'h010, 1, 0);

    // Four not-taken: lookup shows pre-update counter 11,10,01,00
    drive(1, 1, 32'h40, 1, 10'h010, 0, 0);
    chk("nt1_dec", 32'(bif.BP_decision_F), 1);
    drive(1, 1, 32'h40, 1, 10'h010, 0, 0);
    chk("nt2_dec", 32'(bif.BP_decision_F), 1);
    drive(1, 1, 32'h40, 1, 10'h010, 0, 0);
    chk("nt3_dec", 32'(bif.BP_decision_F), 0);
    drive(1, 1, 32'h40, 1, 10'h010, 0, 0);
    chk("nt4_dec", 32'(bif.BP_decision_F), 0);
    // Floor held at 00: two taken steps needed to predict taken again
    drive(1, 1, 32'h40, 1, 10'h010, 1, 0);
    chk("floor_a", 32'(bif.BP_decision_F), 0);
    drive(1, 1, 32'h40, 1, 10'h010, 1, 0);
    chk("floor_b", 32'(bif.BP_decision_F), 0);
    drive(1, 1, 32'h40, 0, 0, 0, 0);
    chk("floor_c", 32'(bif.BP_decision_F), 1);
    chk("stall_ghr", 32'(bif.ghr_spec), 0);

    // Build arch history 0x2A5 with correct resolves
    for (int i = 9; i >= 0; i--) begin
      drive(0, 0, 32'h0, 1, 10'h200, ARCH_PAT[i], 0);
    end
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    chk("ok_res_no_ghr", 32'(bif.ghr_spec), 0);

    // Mispredict with simultaneous fetch branch
    drive(1, 0, 32'h40, 1, 10'h200, 1, 1);
    drive(1, 1, 32'h40, 0, 0, 1, 1);
    chk("recover_ghr", 32'(bif.ghr_spec), 32'h14B);

    // Stall with same-index resolve
    drive(1, 1, 32'h40, 1, 10'h15B, 1, 0);
    chk("corr_no_en", 32'(bif.ghr_spec), 32'h14B);
    chk("bypass_idx", 32'(bif.pred_idx_F), 32'h15B);
    chk("bypass_old", 32'(bif.BP_decision_F), 0);
    drive(1, 1, 32'h40, 1, 10'h15B, 1, 0);
    chk("bypass_new", 32'(bif.BP_decision_F), 1);
    drive(1, 1, 32'h40, 0, 0, 0, 0);
    chk("stall3_dec", 32'(bif.BP_decision_F), 1);
    chk("stall3_ghr", 32'(bif.ghr_spec), 32'h14B);

    // Pseudo-random traffic, model-checked every cycle
    for (int n = 0; n < 300; n++) begin
      logic [PC_W-1:0] pc;
      logic [IDX_W-1:0] ix;
      pc = {$urandom_range(0, 15), 2'b00};
      ix = IDX_W'(((int'(pc) >> 2) & MASK) ^ m_gs);
      if ($urandom_range(0, 3) == 0) ix = IDX_W'($urandom_range(0, 15));
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, pc,
            $urandom_range(0, 1) == 1, ix,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    // Mid-run asynchronous reset
    drive(0, 0, 32'h0, 1, 10'h010, 1, 0);
    drive(0, 0, 32'h0, 1, 10'h010, 1, 0);
    drive(1, 1, 32'h40, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_dec", 32'(bif.BP_decision_F), 0);
    chk("mid_rst_ghr", 32'(bif.ghr_spec), 0);
    chk("mid_rst_idx", 32'(bif.pred_idx_F), 32'h010);
    @(negedge clk);
    #1 rst = 1'b0;
    drive(1, 1, 32'h40, 0, 0, 0, 0);
    chk("post_rst_pht", 32'(bif.BP_decision_F), 0);

`ifdef BP_STATS_EN
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'(i * 4), i < 6, 10'h020, 0, i < 2);
    end
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    chk("stat_lookups", bif.stat_lookups, 10);
    chk("stat_resolved", bif.stat_resolved, 6);
    chk("stat_mispredicts", bif.stat_mispredicts, 2);
    rst = 1'b1;
    #1;
    chk("stat_lookups_rst", bif.stat_lookups, 0);
    chk("stat_resolved_rst", bif.stat_resolved, 0);
    chk("stat_mispredicts_rst", bif.stat_mispredicts, 0);
    @(negedge clk);
    #1 rst = 1'b0;
`endif

    drive(0, 0, 32'h0, 0, 0, 0, 0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
